nibble_deserializer: RTL and testbench

Serial-to-parallel front end for the team's 4-bit data latch stage. Collects single serial bits into WIDTH-bit words, buffers completed words in a small FIFO, and presents them on a valid/ready output whose Data bus drives the downstream latch's data input. Handles frame realignment, back-pressure and overrun reporting so the latch stage only ever sees complete, ordered words.

---
 rtl/nibble_pkg.sv | 16 +
 rtl/nibble_deserializer_sync_fifo.sv | 77 +++++++
 rtl/nibble_deserializer.sv | 114 +++++++++++
 tb/tb_nibble_deserializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble deserializer and its word FIFO.
package nibble_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DefWidth     = 4;
  localparam int unsigned DefFifoDepth = 2;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nibble_deserializer_sync_fifo.sv
// Word FIFO for the deserializer: storage, wrap-around pointers, occupancy count.
module sync_fifo
  import nibble_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  localparam int unsigned PtrW      = ptr_width(FIFO_DEPTH),
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full  = (r_count == FullCount);
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the read port is gated while empty.
  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel front end: assembles WIDTH-bit words and queues them for a valid/ready sink.
module nibble_deserializer
  import nibble_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_serial_in,
  input  logic             i_serial_valid,
  input  logic             i_frame_sync,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_overrun,
  output logic [CntW-1:0]  o_count
);

  localparam int unsigned    BitW    = $clog2(WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("nibble_deserializer: WIDTH must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("nibble_deserializer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_e          r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BitW-1:0] r_bit_cnt;
  logic            r_overrun;

  logic             w_accept;
  logic             w_sync;
  logic [WIDTH-1:0] w_shift_base;
  logic [WIDTH-1:0] w_shift_next;
  logic [BitW-1:0]  w_cnt_base;
  logic             w_done;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drop;

  assign w_accept = i_enable & i_serial_valid;
  assign w_sync   = w_accept & i_frame_sync;

  // A frame sync restarts assembly from an empty word with this bit as bit 0.
  assign w_shift_base = w_sync ? '0 : r_shift;
  assign w_cnt_base   = (w_sync || (r_state == IDLE)) ? '0 : r_bit_cnt;

  if (MSB_FIRST) begin : g_msb_first
    assign w_shift_next = {w_shift_base[WIDTH-2:0], i_serial_in};
  end else begin : g_lsb_first
    assign w_shift_next = {i_serial_in, w_shift_base[WIDTH-1:1]};
  end

  assign w_done = w_accept & (w_cnt_base == LastBit);
  assign w_pop  = i_data_ready & ~w_empty;
  assign w_drop = w_done & w_full & ~w_pop;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else if (!i_enable) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_done) begin
          r_state   <= IDLE;
          r_shift   <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_state   <= SHIFT;
          r_shift   <= w_shift_next;
          r_bit_cnt <= w_cnt_base + BitW'(1);
        end
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (~i_enable),
    .i_push  (w_done),
    .i_wdata (w_shift_next),
    .i_pop   (i_data_ready),
    .o_rdata (o_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  assign o_data_valid = ~w_empty;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: MSB-first and LSB-first instances against a word-level model.
module tb_nibble_deserializer;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic ser;
  logic sval;
  logic fsync;
  logic rdy;

  logic [3:0] d_m, d_l;
  logic       v_m, v_l;
  logic       o_m, o_l;
  logic [1:0] c_m, c_l;

  int checks = 0;
  int errors = 0;

  // Model: bits gathered so far, a two-entry word queue, sticky overrun.
  int         m_nbits [2];
  logic [3:0] m_part  [2];
  logic [3:0] m_q     [2][2];
  int         m_n     [2];
  bit         m_ovr   [2];

  always #5 clk = ~clk;

  nibble_deserializer #(
    .WIDTH      (4),
    .MSB_FIRST  (1'b1),
    .FIFO_DEPTH (2)
  ) dut_m (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_serial_in    (ser),
    .i_serial_valid (sval),
    .i_frame_sync   (fsync),
    .o_data         (d_m),
    .o_data_valid   (v_m),
    .i_data_ready   (rdy),
    .o_overrun      (o_m),
    .o_count        (c_m)
  );

  nibble_deserializer #(
    .WIDTH      (4),
    .MSB_FIRST  (1'b0),
    .FIFO_DEPTH (2)
  ) dut_l (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_serial_in    (ser),
    .i_serial_valid (sval),
    .i_frame_sync   (fsync),
    .o_data         (d_l),
    .o_data_valid   (v_l),
    .i_data_ready   (rdy),
    .o_overrun      (o_l),
    .o_count        (c_l)
  );

  task automatic model_clear(input int k);
    m_nbits[k] = 0;
    m_part[k]  = 4'h0;
    m_n[k]     = 0;
    m_ovr[k]   = 1'b0;
  endtask

  task automatic model_edge(input int k);
    bit         pop;
    bit         done;
    logic [3:0] word;
    if (!en) begin
      model_clear(k);
      return;
    end
    pop  = (m_n[k] > 0) && rdy;
    done = 1'b0;
    word = 4'h0;
    if (sval) begin
      if (fsync) begin
        m_nbits[k] = 0;
        m_part[k]  = 4'h0;
      end
      if (k == 0) m_part[k] = (m_part[k] << 1) | {3'b000, ser};
      else        m_part[k][m_nbits[k]] = ser;
      m_nbits[k]++;
      if (m_nbits[k] == 4) begin
        done       = 1'b1;
        word       = m_part[k];
        m_nbits[k] = 0;
        m_part[k]  = 4'h0;
      end
    end
    if (pop) begin
      m_q[k][0] = m_q[k][1];
      m_n[k]--;
    end
    if (done) begin
      if (m_n[k] < 2) begin
        m_q[k][m_n[k]] = word;
        m_n[k]++;
      end else begin
        m_ovr[k] = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s data%0d", tag, k), (k == 0) ? d_m : d_l,
            (m_n[k] > 0) ? m_q[k][0] : 4'h0);
      check($sformatf("%s valid%0d", tag, k), {3'b000, (k == 0) ? v_m : v_l},
            {3'b000, m_n[k] > 0});
      check($sformatf("%s count%0d", tag, k), {2'b00, (k == 0) ? c_m : c_l}, 4'(m_n[k]));
      check($sformatf("%s ovr%0d", tag, k), {3'b000, (k == 0) ? o_m : o_l},
            {3'b000, m_ovr[k]});
    end
  endtask

  task automatic step(input string tag, input logic s, input logic v, input logic f,
                      input logic r, input logic e);
    ser   = s;
    sval  = v;
    fsync = f;
    rdy   = r;
    en    = e;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(tag);
  endtask

  // Bits of w go out w[3] first.
  task automatic send_word(input string tag, input logic [3:0] w, input logic r);
    for (int i = 3; i >= 0; i--) step(tag, w[i], 1'b1, 1'b0, r, 1'b1);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_clear(0);
    model_clear(1);
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ser = 1'b0; sval = 1'b0; fsync = 1'b0; rdy = 1'b0;
    model_clear(0);
    model_clear(1);
    #1;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    step("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Basic word, both bit orders
    send_word("basic", 4'b1011, 1'b1);
    check("basic msb", d_m, 4'b1011);
    check("basic lsb", d_l, 4'b1101);
    step("basic drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("basic empty", {3'b000, v_m}, 4'h0);

    // Overrun: third word dropped, first two kept in order
    send_word("ovr A", 4'b0011, 1'b0);
    send_word("ovr B", 4'b0101, 1'b0);
    send_word("ovr C", 4'b1001, 1'b0);
    check("ovr count", {2'b00, c_m}, 4'd2);
    check("ovr flag", {3'b000, o_m}, 4'd1);
    check("ovr head A", d_m, 4'b0011);
    step("ovr pop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr head B", d_m, 4'b0101);
    step("ovr pop2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr sticky", {3'b000, o_m}, 4'd1);
    step("ovr clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr cleared", {3'b000, o_m}, 4'd0);

    // Frame sync discards the partial word
    step("fs p1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("fs p2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("fs b0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("fs sync no valid", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("fs bits", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("fs valid", {3'b000, v_m}, 4'd1);
    check("fs word", d_m, 4'b0000);
    check("fs count", {2'b00, c_m}, 4'd1);
    step("fs drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Full FIFO with simultaneous pop: no overrun
    send_word("full A", 4'b1010, 1'b0);
    send_word("full B", 4'b0110, 1'b0);
    step("full c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("full c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("full c1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("full c0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("full count", {2'b00, c_m}, 4'd2);
    check("full no ovr", {3'b000, o_m}, 4'd0);
    check("full head", d_m, 4'b0110);

    // Enable low with data held flushes everything
    step("en low", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("en low valid", {3'b000, v_m}, 4'd0);
    check("en low data", d_m, 4'd0);

    // Async reset mid-word with data queued
    send_word("rst q", 4'b0111, 1'b0);
    step("rst p1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("rst p2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    async_reset("async rst");
    check("rst valid", {3'b000, v_m}, 4'd0);
    send_word("after rst", 4'b1011, 1'b0);
    check("after rst msb", d_m, 4'b1011);
    check("after rst lsb", d_l, 4'b1101);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rand rst");
      step("rand", 1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
